// File: rtl/mdu_unit_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_unit_pkg
// Purpose  : Shared mdu_op encodings and FSM state encoding for mdu_unit.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_unit_pkg;

    localparam logic [3:0] C_OP_NONE  = 4'd0;
    localparam logic [3:0] C_OP_MULT  = 4'd1;
    localparam logic [3:0] C_OP_MULTU = 4'd2;
    localparam logic [3:0] C_OP_DIV   = 4'd3;
    localparam logic [3:0] C_OP_DIVU  = 4'd4;
    localparam logic [3:0] C_OP_MFHI  = 4'd5;
    localparam logic [3:0] C_OP_MFLO  = 4'd6;
    localparam logic [3:0] C_OP_MTHI  = 4'd7;
    localparam logic [3:0] C_OP_MTLO  = 4'd8;
    localparam logic [3:0] C_OP_MADD  = 4'd9;
    localparam logic [3:0] C_OP_MADDU = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == C_OP_MULT) || (op == C_OP_MULTU) ||
               (op == C_OP_MADD) || (op == C_OP_MADDU);
`else
        return (op == C_OP_MULT) || (op == C_OP_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == C_OP_DIV) || (op == C_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_unit_if
// Purpose  : Request/result bundle between the execute stage and mdu_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_unit_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_out;

    modport master (
        output start, mdu_op, src_a, src_b,
        input  busy, hi, lo, mf_out
    );

    modport slave (
        input  start, mdu_op, src_a, src_b,
        output busy, hi, lo, mf_out
    );
endinterface
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mdu_unit
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; optional
//            MADD/MADDU accumulate enabled by defining MDU_MADD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mdu_unit_if.slave   bus
);

    mdu_state_t  r_state;
    logic        r_busy;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_arith_req;
    logic        w_done;
    logic [3:0]  w_load;
    logic        w_div_signed;
    logic        w_div_zero;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_mul_s;
    logic [63:0] w_mul_u;
    logic [63:0] w_result;

    assign w_is_mul    = is_mul_op(bus.mdu_op);
    assign w_is_div    = is_div_op(bus.mdu_op);
    assign w_arith_req = bus.start && (w_is_mul || w_is_div);
    assign w_load      = w_is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
    assign w_done      = (r_state == ST_RUN) && (r_cnt == 4'd1);

    assign w_a_sx  = {{32{r_a[31]}}, r_a};
    assign w_b_sx  = {{32{r_b[31]}}, r_b};
    assign w_mul_s = w_a_sx * w_b_sx;
    assign w_mul_u = {32'd0, r_a} * {32'd0, r_b};

    // One unsigned divider serves both DIV and DIVU: signed operands are
    // reduced to magnitudes and the signs reapplied afterwards.
    assign w_div_signed = (r_op == C_OP_DIV);
    assign w_dvd   = (w_div_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_dvs   = (w_div_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_q_mag = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
    assign w_r_mag = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
    assign w_quot  = (w_div_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = (w_div_signed && r_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_div_zero = is_div_op(r_op) && (r_b == 32'd0);

    always_comb begin
        w_result = {r_hi, r_lo};
        case (r_op)
            C_OP_MULT:  w_result = w_mul_s;
            C_OP_MULTU: w_result = w_mul_u;
            C_OP_DIV,
            C_OP_DIVU:  w_result = {w_rem, w_quot};
`ifdef MDU_MADD_EN
            C_OP_MADD:  w_result = {r_hi, r_lo} + w_mul_s;
            C_OP_MADDU: w_result = {r_hi, r_lo} + w_mul_u;
`endif
            default:    w_result = {r_hi, r_lo};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
            r_op    <= C_OP_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arith_req) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= w_load;
                        r_op    <= bus.mdu_op;
                        r_a     <= bus.src_a;
                        r_b     <= bus.src_b;
                    end else if (bus.mdu_op == C_OP_MTHI) begin
                        r_hi <= bus.src_a;
                    end else if (bus.mdu_op == C_OP_MTLO) begin
                        r_lo <= bus.src_a;
                    end
                end
                ST_RUN: begin
                    if (w_done) begin
                        // Division by zero leaves HI/LO untouched.
                        if (!w_div_zero) begin
                            r_hi <= w_result[63:32];
                            r_lo <= w_result[31:0];
                        end
                        if (w_arith_req) begin
                            r_cnt <= w_load;
                            r_op  <= bus.mdu_op;
                            r_a   <= bus.src_a;
                            r_b   <= bus.src_b;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_cnt   <= 4'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;
    assign bus.mf_out = (bus.mdu_op == C_OP_MFHI) ? r_hi :
                        (bus.mdu_op == C_OP_MFLO) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mdu_unit
// Purpose  : Scoreboard bench for mdu_unit with directed, hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    typedef struct {
        string       name;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    mdu_unit_if bus();

    mdu_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
        @(posedge clk);
        #1;
        bus.start  = st;
        bus.mdu_op = op;
        bus.src_a  = a;
        bus.src_b  = b;
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.mdu_op = C_OP_NONE;
        bus.src_a  = 32'd0;
        bus.src_b  = 32'd0;
    endtask

    task automatic wait_idle(input string name);
        logic seen_idle;
        seen_idle = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                seen_idle = 1'b1;
                break;
            end
        end
        if (!seen_idle) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input logic [31:0] ehi,
                          input logic [31:0] elo);
        exp_t e;
        e.name = name; e.cycles = cyc; e.hi = ehi; e.lo = elo;
        sb.push_back(e);
        drive(op, a, b, 1'b1);
        drive_idle();
        wait_idle(name);
    endtask

    // Monitor: counts busy cycles and scores each completion against the queue.
    initial begin : monitor
        int   cnt;
        logic prev;
        exp_t e;
        cnt  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt  = 0;
                prev = 1'b0;
            end else begin
                if (bus.busy) begin
                    cnt++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_cycles"}, 32'(cnt), 32'(e.cycles));
                        check({e.name, "_hi"}, bus.hi, e.hi);
                        check({e.name, "_lo"}, bus.lo, e.lo);
                    end
                    cnt = 0;
                end
                prev = bus.busy;
            end
        end
    end

    initial begin : stimulus
        exp_t e;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.mdu_op = C_OP_NONE;
        bus.src_a  = 32'd0;
        bus.src_b  = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_mf", bus.mf_out, 32'd0);

        run_op("mult_m3x5",   C_OP_MULT,  32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("divu_100_7",  C_OP_DIVU,  32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div_m7_2",    C_OP_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",    C_OP_DIV,   32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
        run_op("div_ovf",     C_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("multu_max",   C_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

        // MTHI/MTLO then MFHI/MFLO
        drive(C_OP_MTHI, 32'h1234, 32'd0, 1'b0);
        drive_idle();
        check("mthi_hi", bus.hi, 32'h1234);
        drive(C_OP_MFHI, 32'd0, 32'd0, 1'b0);
        #1 check("mfhi_out", bus.mf_out, 32'h1234);
        drive(C_OP_MTLO, 32'h5678, 32'd0, 1'b0);
        drive(C_OP_MFLO, 32'd0, 32'd0, 1'b0);
        #1 check("mflo_out", bus.mf_out, 32'h5678);
        drive_idle();

        // Prime HI/LO, then divide by zero with an MTLO attempted mid-run
        drive(C_OP_MTHI, 32'hA, 32'd0, 1'b0);
        drive(C_OP_MTLO, 32'hB, 32'd0, 1'b0);
        e.name = "div_zero"; e.cycles = 10; e.hi = 32'hA; e.lo = 32'hB;
        sb.push_back(e);
        drive(C_OP_DIV, 32'd5, 32'd0, 1'b1);
        drive_idle();
        drive(C_OP_MTLO, 32'h999, 32'd0, 1'b0);
        drive_idle();
        check("mtlo_busy_lo", bus.lo, 32'hB);
        wait_idle("div_zero");

        // Start while busy: MULTU must be dropped
        e.name = "div_busy"; e.cycles = 10; e.hi = 32'd2; e.lo = 32'd14;
        sb.push_back(e);
        drive(C_OP_DIV, 32'd100, 32'd7, 1'b1);
        drive_idle();
        repeat (2) @(posedge clk);
        drive(C_OP_MULTU, 32'd3, 32'd4, 1'b1);
        drive_idle();
        wait_idle("div_busy");
        repeat (3) @(negedge clk);
        check("ignored_multu_busy", {31'd0, bus.busy}, 32'd0);
        check("ignored_multu_lo", bus.lo, 32'd14);

        // start with NONE has no effect
        drive(C_OP_NONE, 32'd1, 32'd2, 1'b1);
        drive_idle();
        @(negedge clk);
        check("none_busy", {31'd0, bus.busy}, 32'd0);
`ifndef MDU_MADD_EN
        drive(C_OP_MADD, 32'd1, 32'd2, 1'b1);
        drive_idle();
        @(negedge clk);
        check("madd_off_busy", {31'd0, bus.busy}, 32'd0);
        check("madd_off_lo", bus.lo, 32'd14);
`endif

        // Reset during busy cycle 3 discards the pending MULT
        drive(C_OP_MULT, 32'd7, 32'd9, 1'b1);
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("post_rst_hi", bus.hi, 32'd0);
        check("post_rst_lo", bus.lo, 32'd0);

        run_op("mult_7x9", C_OP_MULT, 32'd7, 32'd9, 5, 32'd0, 32'd63);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit: performs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and owns the HI/LO architectural registers.
- Drives the `start` and `busy` signals consumed by the pipeline stall unit, which freezes IFU/D/E while `start || busy`.
- Also serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- MULT_CYCLES, 5: busy-cycle count for MULT/MULTU (legal 1..15).
- DIV_CYCLES, 10: busy-cycle count for DIV/DIVU (legal 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request. Qualifies `mdu_op` for the four arithmetic ops; sampled on the rising edge.
- mdu_op  input  4  operation code from the shared constants header: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO (MADD, MADDU only with the optional feature).
- src_a  input  32  rs operand, forwarded value.
- src_b  input  32  rt operand, forwarded value.
- busy  output  1  high while an arithmetic op is in flight. Goes to the stall unit as E_busy.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- mf_out  output  32  combinational: HI when mdu_op==MFHI, LO when mdu_op==MFLO, else 0.

Behaviour:
- Reset (async, active-high): busy=0, hi=0, lo=0, counter=0, latched operands/op cleared, FSM to IDLE. Reset mid-operation discards the pending result.
- FSM states:
  - IDLE -> RUN on `start && !busy && mdu_op in {MULT, MULTU, DIV, DIVU}`. That edge latches src_a, src_b and op, and loads the counter with MULT_CYCLES or DIV_CYCLES.
  - RUN: counter decrements every cycle. When counter==1, the next edge writes HI/LO, clears busy and returns to IDLE.
- Timing: with start sampled at edge T, busy=1 for exactly N cycles after T. New HI/LO and busy=0 are visible together after edge T+N. Back-to-back: a new start may be sampled on the edge that ends RUN.
- start while busy: ignored; state and latched operands are unchanged. The stall unit prevents this; the bench checks it anyway.
- MTHI/MTLO: write src_a into hi or lo on the edge, only when !busy. Ignored while busy.
- MFHI/MFLO: no state change; mf_out is combinational from the current registers.
- Arithmetic:
  - MULT: signed 32x32 to 64 bits, {hi,lo}=product.
  - MULTU: unsigned 32x32 to 64 bits, {hi,lo}=product.
  - DIV: signed. lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - The result is computed from the latched operands, never from live inputs.
- Boundary cases:
  - DIV/DIVU with divisor 0: full busy period runs; hi/lo retain their prior values.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mdu_op NONE or start=0: no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds MADD/MADDU. Each uses MULT_CYCLES latency; on completion {hi,lo} = {hi,lo} + product (signed/unsigned 64-bit product), modulo 2^64. The accumulator base is the HI/LO value at completion time.
- Undefined: MADD/MADDU codes are treated as NONE. The start is ignored and busy does not assert.

Decomposition:
- Shared constants header (alongside the instruction-type include): mdu_op encodings and FSM state encodings.
- No sub-module. Datapath is one 64-bit result mux fed by the latched operands, plus a 4-bit counter and a 1-bit FSM, all in mdu_unit.

Test Plan:
- MULT -3 x 5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 100 / 7 -> busy high exactly 10 cycles; then lo=14, hi=2.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MFHI -> hi=0x1234 on the next cycle and mf_out=0x1234.
- MTLO while busy -> lo unchanged.
- DIV by 0 with prior hi/lo=0xA/0xB -> after 10 cycles hi/lo remain 0xA/0xB.
- Reset mid-op: MULT started, reset asserted in busy cycle 3 -> busy/hi/lo=0 immediately and no later update.
- Start while busy: MULTU issued during a running DIV -> DIV result correct, MULTU never executed.
